// File: rtl/bitminer_pkg.sv
// Shared bitminer types: PID constants, packet kinds, tx FSM states
// and the reflected CRC16 (USB) byte update used by tx and rx sides.
package bitminer_pkg;

    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NACK  = 8'h5A;

    localparam logic [15:0] CRC16_POLY = 16'hA001;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        PKT_HS,
        PKT_DATA,
        PKT_ZLP
    } pkt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_DATA,
        S_CRCL,
        S_CRCH
    } tx_state_t;

    function automatic logic [15:0] crc16_byte(
        input logic [15:0] c,
        input logic [7:0]  d
    );
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC16_POLY) : (r >> 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/crc16_usb.sv
// CRC16 (USB) register, one byte per enabled cycle, LSB first.
// Shared between the transmit builder and the receive checker.
module crc16_usb
    import bitminer_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // next value: init wins over an update in the same cycle
    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC16_INIT;
        end else if (en) begin
            crc_d = crc16_byte(crc_q, data);
        end
    end

    // CRC state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/tx_packet_builder.sv
// Frames handshake / data / zero-length packets into a byte stream
// over valid/ready: PID, optional payload, complemented CRC16.
module tx_packet_builder
    import bitminer_pkg::*;
#(
    parameter int PAYLOAD_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       transmit_start,
    input  logic                       transmit_empty,
    input  logic                       transmit_ack,
    input  logic [7:0]                 pid_byte,
    input  logic [8*PAYLOAD_BYTES-1:0] hash_data,
    input  logic                       tx_ready,
    output logic [7:0]                 tx_byte,
    output logic                       tx_valid,
    output logic                       tx_eop,
    output logic                       busy,
    output logic                       tx_done,
    output logic                       pid_err
);

    localparam int CW = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(PAYLOAD_BYTES - 1);

    tx_state_t                  state_q;
    pkt_t                       ptype_q;
    logic [7:0]                 pid_q;
    logic [8*PAYLOAD_BYTES-1:0] pay_q;
    logic [CW-1:0]              cnt_q;
    logic                       done_q;
    logic                       perr_q;

    logic        req_any;
    pkt_t        req_type_d;
    logic        pid_ok;
    logic        accept;
    logic        xfer;
    logic [15:0] crc;

    // request decode: ack beats start beats empty
    always_comb begin
        req_any    = 1'b1;
        req_type_d = PKT_HS;
        priority case (1'b1)
            transmit_ack:   req_type_d = PKT_HS;
            transmit_start: req_type_d = PKT_DATA;
            transmit_empty: req_type_d = PKT_ZLP;
            default:        req_any    = 1'b0;
        endcase
    end

    assign pid_ok   = (pid_byte[7:4] == ~pid_byte[3:0]);
    assign accept   = (state_q == S_IDLE) && req_any && pid_ok;
    assign tx_valid = (state_q != S_IDLE);
    assign busy     = tx_valid;
    assign xfer     = tx_valid && tx_ready;
    assign tx_done  = done_q;
    assign pid_err  = perr_q;

    crc16_usb u_crc (
        .clk   (clk),
        .n_rst (n_rst),
        .init  (accept),
        .en    (xfer && (state_q == S_DATA)),
        .data  (pay_q[7:0]),
        .crc   (crc)
    );

    // byte mux and end-of-packet flag from current state
    always_comb begin
        tx_byte = 8'h00;
        tx_eop  = 1'b0;
        unique case (state_q)
            S_PID: begin
                tx_byte = pid_q;
                tx_eop  = (ptype_q == PKT_HS);
            end
            S_DATA: tx_byte = pay_q[7:0];
            S_CRCL: tx_byte = ~crc[7:0];
            S_CRCH: begin
                tx_byte = ~crc[15:8];
                tx_eop  = 1'b1;
            end
            default: tx_byte = 8'h00;
        endcase
    end

    // packet FSM with latched request and payload shifter
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            ptype_q <= PKT_HS;
            pid_q   <= 8'h00;
            pay_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            perr_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_any && !pid_ok) begin
                        perr_q <= 1'b1;
                    end else if (accept) begin
                        state_q <= S_PID;
                        ptype_q <= req_type_d;
                        pid_q   <= pid_byte;
                        pay_q   <= hash_data;
                        cnt_q   <= '0;
                    end
                end
                S_PID: begin
                    if (xfer) begin
                        unique case (ptype_q)
                            PKT_HS: begin
                                state_q <= S_IDLE;
                                done_q  <= 1'b1;
                            end
                            PKT_DATA: state_q <= S_DATA;
                            default:  state_q <= S_CRCL;
                        endcase
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        pay_q <= pay_q >> 8;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            state_q <= S_CRCL;
                        end
                    end
                end
                S_CRCL: begin
                    if (xfer) begin
                        state_q <= S_CRCH;
                    end
                end
                S_CRCH: begin
                    if (xfer) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_packet_builder.sv
// Directed bench for tx_packet_builder: handshake, zero-length, data,
// backpressure, PID rejection, priority, busy drop and mid-packet reset.
module tb_tx_packet_builder;

    localparam int PB = 4;

    logic          clk;
    logic          n_rst;
    logic          transmit_start;
    logic          transmit_empty;
    logic          transmit_ack;
    logic [7:0]    pid_byte;
    logic [8*PB-1:0] hash_data;
    logic          tx_ready;
    logic [7:0]    tx_byte;
    logic          tx_valid;
    logic          tx_eop;
    logic          busy;
    logic          tx_done;
    logic          pid_err;

    int n_chk;
    int n_fail;
    logic [7:0] rx_b[$];
    logic       rx_e[$];
    logic [7:0] exp_q[$];
    int         ncyc;

    tx_packet_builder #(.PAYLOAD_BYTES(PB)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .transmit_start (transmit_start),
        .transmit_empty (transmit_empty),
        .transmit_ack   (transmit_ack),
        .pid_byte       (pid_byte),
        .hash_data      (hash_data),
        .tx_ready       (tx_ready),
        .tx_byte        (tx_byte),
        .tx_valid       (tx_valid),
        .tx_eop         (tx_eop),
        .busy           (busy),
        .tx_done        (tx_done),
        .pid_err        (pid_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_crc(input logic [7:0] b[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (b[k]) begin
            for (int j = 0; j < 8; j++) begin
                if (c[0] ^ b[k][j]) c = (c >> 1) ^ 16'hA001;
                else                c = c >> 1;
            end
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic req(input logic a, input logic s, input logic e,
                       input logic [7:0] p, input logic [31:0] h);
        transmit_ack   = a;
        transmit_start = s;
        transmit_empty = e;
        pid_byte       = p;
        hash_data      = h;
        @(negedge clk);
        transmit_ack   = 1'b0;
        transmit_start = 1'b0;
        transmit_empty = 1'b0;
        pid_byte       = 8'h00;
        hash_data      = '0;
    endtask

    task automatic capture(input bit bp, input int budget);
        logic [7:0] hb;
        logic       he;
        bit         hold;
        bit         done;
        rx_b.delete();
        rx_e.delete();
        hold = 0;
        done = 0;
        hb   = 8'h00;
        he   = 1'b0;
        ncyc = 0;
        for (int c = 0; c < budget && !done; c++) begin
            if (hold) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_byte", 32'(tx_byte), 32'(hb));
                chk("hold_eop", 32'(tx_eop), 32'(he));
            end
            if (tx_done) begin
                done = 1;
            end else begin
                tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (tx_valid && tx_ready) begin
                    rx_b.push_back(tx_byte);
                    rx_e.push_back(tx_eop);
                    hold = 0;
                end else if (tx_valid) begin
                    hold = 1;
                    hb   = tx_byte;
                    he   = tx_eop;
                end
                @(negedge clk);
                ncyc++;
            end
        end
        tx_ready = 1'b1;
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic cmp_pkt(input string tag);
        chk({tag, "_len"}, 32'(rx_b.size()), 32'(exp_q.size()));
        for (int i = 0; i < rx_b.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i), 32'(rx_b[i]), 32'(exp_q[i]));
            chk($sformatf("%s_e%0d", tag, i), 32'(rx_e[i]),
                32'(i == exp_q.size() - 1));
        end
    endtask

    task automatic exp_data(input logic [31:0] h);
        logic [7:0] pl[$];
        logic [15:0] c;
        pl.delete();
        for (int i = 0; i < PB; i++) pl.push_back(h[8*i +: 8]);
        c = ~ref_crc(pl);
        exp_q.delete();
        exp_q.push_back(8'hC3);
        foreach (pl[i]) exp_q.push_back(pl[i]);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        n_rst = 1'b0;
        transmit_start = 1'b0;
        transmit_empty = 1'b0;
        transmit_ack = 1'b0;
        pid_byte = 8'h00;
        hash_data = '0;
        tx_ready = 1'b1;

        #3;
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_byte", 32'(tx_byte), 32'd0);
        chk("rst_eop", 32'(tx_eop), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_perr", 32'(pid_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // ACK handshake packet
        req(1, 0, 0, 8'hD2, 32'h0);
        chk("ack_busy", 32'(busy), 32'd1);
        capture(0, 20);
        exp_q = '{8'hD2};
        cmp_pkt("ack");
        chk("ack_lat", 32'(ncyc), 32'd1);
        chk("ack_busy_done", 32'(busy), 32'd0);

        // zero-length data packet
        req(0, 0, 1, 8'hC3, 32'h0);
        capture(0, 20);
        exp_q = '{8'hC3, 8'h00, 8'h00};
        cmp_pkt("zlp");

        // full data packet
        req(0, 1, 0, 8'hC3, 32'h03020100);
        capture(0, 40);
        exp_data(32'h03020100);
        cmp_pkt("data");

        // data packet under random backpressure
        req(0, 1, 0, 8'hC3, 32'hA55A0FF0);
        capture(1, 400);
        exp_data(32'hA55A0FF0);
        cmp_pkt("bp");

        // bad PID rejected
        req(0, 1, 0, 8'hC4, 32'h11223344);
        chk("bad_perr", 32'(pid_err), 32'd1);
        chk("bad_busy", 32'(busy), 32'd0);
        chk("bad_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        chk("bad_perr_off", 32'(pid_err), 32'd0);
        chk("bad_valid2", 32'(tx_valid), 32'd0);

        // ack and start together: ack wins
        req(1, 1, 0, 8'hD2, 32'h01020304);
        capture(0, 20);
        exp_q = '{8'hD2};
        cmp_pkt("prio_as");

        // start and empty together: start wins
        req(0, 1, 1, 8'hC3, 32'h0BADF00D);
        capture(0, 40);
        exp_data(32'h0BADF00D);
        cmp_pkt("prio_se");

        // request while busy is dropped
        tx_ready = 1'b0;
        req(0, 1, 0, 8'hC3, 32'h44332211);
        req(1, 0, 0, 8'h5A, 32'h0);
        chk("busy_pid", 32'(tx_byte), 32'hC3);
        capture(0, 40);
        exp_data(32'h44332211);
        cmp_pkt("drop");
        @(negedge clk);
        @(negedge clk);
        chk("drop_idle", 32'(tx_valid), 32'd0);

        // reset in the middle of the payload
        req(0, 1, 0, 8'hC3, 32'h03020100);
        @(negedge clk);
        @(negedge clk);
        chk("mid_byte", 32'(tx_byte), 32'h01);
        #2 n_rst = 1'b0;
        #1;
        chk("mr_valid", 32'(tx_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_byte", 32'(tx_byte), 32'd0);
        chk("mr_eop", 32'(tx_eop), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("mr_idle", 32'(tx_valid), 32'd0);

        // clean packets after reset
        req(0, 1, 0, 8'hC3, 32'hDEADBEEF);
        capture(0, 40);
        exp_data(32'hDEADBEEF);
        cmp_pkt("post");
        req(1, 0, 0, 8'h5A, 32'h0);
        capture(0, 20);
        exp_q = '{8'h5A};
        cmp_pkt("nack");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
